// File: rtl/hazard_forward_unit.sv
// Hazard unit for the 5-stage RISC-V core: ALU operand forwarding, load-use stall,
// branch flush, and saturating stall/flush cycle counters.
module hazard_forward_unit #(
   parameter bit FORWARD_EN = 1'b1,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic             RegWriteE,
   input  logic             LoadE,
   input  logic             PCSrcE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             FlushD,
   output logic             FlushE,
   output logic [CNT_W-1:0] stall_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [4:0]       rd_m_q, rd_m_d;
   logic [4:0]       rd_w_q, rd_w_d;
   logic             reg_write_m_q, reg_write_m_d;
   logic             reg_write_w_q, reg_write_w_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lw_stall_s;

   // Newest writer wins; x0 is hard-wired zero and never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rd_m, input logic we_m,
                                          input logic [4:0] rd_w, input logic we_w);
      logic [1:0] sel;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (we_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and pipeline control outputs
   always_comb begin
      lw_stall_s = 1'b0;
      ForwardAE  = 2'b00;
      ForwardBE  = 2'b00;
      StallF     = 1'b0;
      StallD     = 1'b0;
      FlushD     = 1'b1;
      FlushE     = 1'b1;
      if (reset) begin
         lw_stall_s = 1'b0;
      end else begin
         lw_stall_s = LoadE && RegWriteE && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
         StallF     = lw_stall_s;
         StallD     = lw_stall_s;
         FlushD     = PCSrcE;
         FlushE     = lw_stall_s || PCSrcE;
         if (FORWARD_EN == 1'b1) begin
            ForwardAE = fwd_sel(Rs1E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
            ForwardBE = fwd_sel(Rs2E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
         end else begin
            ForwardAE = 2'b00;
            ForwardBE = 2'b00;
         end
      end
   end

   // Next-state for the M/W tag pipeline and the saturating counters
   always_comb begin
      rd_m_d        = RdE;
      reg_write_m_d = RegWriteE;
      rd_w_d        = rd_m_q;
      reg_write_w_d = reg_write_m_q;
      stall_cnt_d   = stall_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      if (lw_stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (PCSrcE && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // State registers; tags advance every cycle, stalls bubble E externally
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_m_q        <= 5'd0;
         rd_w_q        <= 5'd0;
         reg_write_m_q <= 1'b0;
         reg_write_w_q <= 1'b0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
      end else begin
         rd_m_q        <= rd_m_d;
         rd_w_q        <= rd_w_d;
         reg_write_m_q <= reg_write_m_d;
         reg_write_w_q <= reg_write_w_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
      end
   end

   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench for hazard_forward_unit: directed test-plan scenarios plus
// randomized stimulus against a history-queue reference model.
module tb_hazard_forward_unit;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] Rs1D = 5'd0, Rs2D = 5'd0, Rs1E = 5'd0, Rs2E = 5'd0, RdE = 5'd0;
   logic       RegWriteE = 1'b0, LoadE = 1'b0, PCSrcE = 1'b0;

   logic [1:0]  fa, fb;
   logic        stall_f, stall_d, flush_d, flush_e;
   logic [31:0] stall_cnt, flush_cnt;

   logic [1:0]  sat_fa, sat_fb;
   logic        sat_stall_f, sat_stall_d, sat_flush_d, sat_flush_e;
   logic [1:0]  sat_stall_cnt, sat_flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [4:0] rd;
      bit         we;
   } tag_t;
   tag_t hist[$];          // index 0 = instruction now in M, index 1 = in W
   int   exp_stalls = 0;
   int   exp_flushes = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.FORWARD_EN(1'b1), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
      .ForwardAE(fa), .ForwardBE(fb), .StallF(stall_f), .StallD(stall_d),
      .FlushD(flush_d), .FlushE(flush_e), .stall_count(stall_cnt), .flush_count(flush_cnt)
   );

   hazard_forward_unit #(.FORWARD_EN(1'b1), .CNT_W(2)) dut_sat (
      .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RegWriteE(RegWriteE), .LoadE(LoadE), .PCSrcE(PCSrcE),
      .ForwardAE(sat_fa), .ForwardBE(sat_fb), .StallF(sat_stall_f), .StallD(sat_stall_d),
      .FlushD(sat_flush_d), .FlushE(sat_flush_e), .stall_count(sat_stall_cnt),
      .flush_count(sat_flush_cnt)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [1:0] model_fwd(input logic [4:0] rs);
      if (rs == 5'd0) return 2'b00;
      for (int i = 0; i < hist.size(); i++) begin
         if (hist[i].we && hist[i].rd == rs) return (i == 0) ? 2'b10 : 2'b01;
      end
      return 2'b00;
   endfunction

   function automatic bit model_lw();
      return LoadE && RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   endfunction

   task automatic check_outputs(input string tag);
      bit         lw;
      logic [1:0] efa, efb;
      int         es, ef;
      lw  = !reset && model_lw();
      efa = reset ? 2'b00 : model_fwd(Rs1E);
      efb = reset ? 2'b00 : model_fwd(Rs2E);
      es  = reset ? 0 : exp_stalls;
      ef  = reset ? 0 : exp_flushes;
      check_val({tag, ".fa"}, 32'(fa), 32'(efa));
      check_val({tag, ".fb"}, 32'(fb), 32'(efb));
      check_val({tag, ".stallF"}, 32'(stall_f), 32'(lw));
      check_val({tag, ".stallD"}, 32'(stall_d), 32'(lw));
      check_val({tag, ".flushD"}, 32'(flush_d), 32'(reset || PCSrcE));
      check_val({tag, ".flushE"}, 32'(flush_e), 32'(reset || PCSrcE || lw));
      check_val({tag, ".scnt"}, stall_cnt, 32'(es));
      check_val({tag, ".fcnt"}, flush_cnt, 32'(ef));
      check_val({tag, ".sat_scnt"}, 32'(sat_stall_cnt), 32'((es > 3) ? 3 : es));
      check_val({tag, ".sat_fcnt"}, 32'(sat_flush_cnt), 32'((ef > 3) ? 3 : ef));
      check_val({tag, ".sat_fa"}, 32'(sat_fa), 32'(efa));
      check_val({tag, ".sat_stallF"}, 32'(sat_stall_f), 32'(lw));
   endtask

   task automatic apply(input string tag, input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde,
                        input logic rwe, lde, pcs);
      Rs1D = rs1d; Rs2D = rs2d; Rs1E = rs1e; Rs2E = rs2e; RdE = rde;
      RegWriteE = rwe; LoadE = lde; PCSrcE = pcs;
      #2;
      check_outputs(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset) begin
         hist.delete();
         exp_stalls  = 0;
         exp_flushes = 0;
      end else begin
         if (model_lw()) exp_stalls++;
         if (PCSrcE) exp_flushes++;
         hist.push_front('{rd: RdE, we: RegWriteE});
         if (hist.size() > 2) void'(hist.pop_back());
      end
      #1;
   endtask

   initial begin
      // Reset state, including inputs that would otherwise stall and flush
      apply("rst", 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      check_val("rst_flushE", 32'(flush_e), 32'd1);
      tick(); tick();
      reset = 1'b0;

      // ALU chain
      apply("alu0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0); tick();
      apply("alu1", 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("alu_chain_fa", 32'(fa), 32'd2); tick();
      apply("alu2", 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("alu_chain_fb", 32'(fb), 32'd1); tick();

      // Double hazard, then with the M writer disabled
      apply("dbl0", 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
      apply("dbl1", 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
      apply("dbl2", 5'd0, 5'd0, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("double_fa_m", 32'(fa), 32'd2); tick();
      apply("dbl3", 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0); tick();
      apply("dbl4", 5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0); tick();
      apply("dbl5", 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("double_fa_w", 32'(fa), 32'd1); tick();

      // x0 suppression
      apply("x0a", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0); tick();
      apply("x0b", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      check_val("x0_fa", 32'(fa), 32'd0);
      check_val("x0_nostall", 32'(stall_f), 32'd0); tick();

      // Load-use: one-cycle stall, then bubble, then W forward of the load
      apply("lu0", 5'd0, 5'd3, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
      check_val("lu_stall", 32'(stall_d), 32'd1); tick();
      apply("lu1", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("lu_scnt", stall_cnt, 32'd1);
      check_val("lu_stall_off", 32'(stall_f), 32'd0); tick();
      apply("lu2", 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("lu_fb_w", 32'(fb), 32'd1); tick();

      // Taken branch together with a load-use hazard
      apply("br0", 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b1);
      check_val("br_flushD", 32'(flush_d), 32'd1); tick();
      apply("br1", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("br_scnt", stall_cnt, 32'd2);
      check_val("br_fcnt", flush_cnt, 32'd1);

      // Asynchronous reset mid-stall
      apply("mid0", 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      check_outputs("mid_rst");
      check_val("mid_rst_stall", 32'(stall_f), 32'd0);
      check_val("mid_rst_scnt", stall_cnt, 32'd0);
      tick();
      reset = 1'b0;

      // Saturation of the 2-bit counters over 5 consecutive stalls
      for (int i = 0; i < 5; i++) begin
         apply("sat", 5'd9, 5'd0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 1'b0);
         tick();
      end
      apply("sat_end", 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      check_val("sat_hold3", 32'(sat_stall_cnt), 32'd3);
      check_val("sat_wide5", stall_cnt, 32'd5);

      // Randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 39) == 0);
         apply("rnd", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
         tick();
      end
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Execute-side consumer of the ID/EX register outputs (RdE, RSD1_E, RSD2_E) in the 5-stage pipelined RISC-V core.
- Carries its own tag pipeline of destination register and write-enable through the M and W stages.
- Generates ALU operand forwarding selects, load-use stall, and branch flush controls.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- FORWARD_EN, 1, 1 = forwarding enabled; 0 = ForwardAE/ForwardBE are tied to 00 (ablation/debug).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Rs1D  input  5  rs1 of the instruction in decode
- Rs2D  input  5  rs2 of the instruction in decode
- Rs1E  input  5  rs1 in execute (from ID/EX RSD1_E)
- Rs2E  input  5  rs2 in execute (from ID/EX RSD2_E)
- RdE  input  5  rd in execute
- RegWriteE  input  1  execute instruction writes the register file
- LoadE  input  1  execute instruction is a load (ResultSrcE = memory)
- PCSrcE  input  1  branch/jump taken, resolved in execute
- ForwardAE  output  2  operand A select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW
- ForwardBE  output  2  operand B select, same encoding
- StallF  output  1  hold PC
- StallD  output  1  hold IF/ID
- FlushD  output  1  clear IF/ID
- FlushE  output  1  clear ID/EX
- stall_count  output  CNT_W  cycles with a load-use stall
- flush_count  output  CNT_W  cycles with PCSrcE asserted

Behaviour:
- Tag pipeline (internal registers RdM, RegWriteM, RdW, RegWriteW):
  - Updated every posedge: RdM <= RdE, RegWriteM <= RegWriteE, RdW <= RdM, RegWriteW <= RegWriteM.
  - Tags are never gated by stall: a stalled cycle inserts an externally flushed bubble in E (RegWriteE = 0), and that bubble propagates into M.
- Forwarding (combinational from the tag registers and Rs1E/Rs2E):
  - ForwardAE = 10 if RegWriteM && RdM != 0 && RdM == Rs1E.
  - Else ForwardAE = 01 if RegWriteW && RdW != 0 && RdW == Rs1E.
  - Else ForwardAE = 00.
  - M has priority over W; x0 is never forwarded. ForwardBE uses the same rules with Rs2E.
- Load-use stall:
  - lwStall = LoadE && RegWriteE && RdE != 0 && (RdE == Rs1D || RdE == Rs2D).
  - StallF = StallD = lwStall.
- Flushes:
  - FlushD = PCSrcE.
  - FlushE = lwStall || PCSrcE.
  - If PCSrcE and lwStall occur together, both stalls and both flushes assert. The taken branch wins: the decode instruction is discarded anyway.
- Latency: all control outputs are combinational, valid in the same cycle as their inputs. The tag pipeline adds 1 and 2 cycles of delay for the M and W views.
- Counters:
  - stall_count increments on each posedge where lwStall = 1.
  - flush_count increments on each posedge where PCSrcE = 1.
  - Both saturate at 2^CNT_W - 1 and do not wrap.
- Reset (asynchronous, takes effect immediately):
  - RdM, RdW = 0; RegWriteM, RegWriteW = 0; counters = 0.
  - Therefore ForwardAE = ForwardBE = 00.
  - While reset is high: StallF = StallD = 0, FlushD = FlushE = 1, regardless of inputs.
  - Reset asserted mid-stall drops the stall immediately, and no counter increment occurs for that cycle.
  - After deassertion, the first posedge loads tags from the E inputs normally.
- Boundary cases:
  - Rs1E == Rs2E: both selects are computed identically.
  - RdM == RdW, both writing: select 10 (newest value).
  - Loads in M are never forwarded from the M stage, because the stall guarantees a one-cycle gap.

Test Plan:
- ALU chain: add x5 (RdE = 5, RegWriteE = 1), next cycle Rs1E = 5 -> ForwardAE = 10; following cycle Rs2E = 5 with no newer writer -> ForwardBE = 01.
- Double hazard: RdM = RdW = 7, both writing, Rs1E = 7 -> ForwardAE = 10. Repeat with RegWriteM = 0 -> ForwardAE = 01.
- x0 suppression: RdE = 0, RegWriteE = 1, then Rs1E = Rs2E = 0 -> ForwardAE = ForwardBE = 00. LoadE = 1 with RdE = 0 and Rs1D = 0 -> no stall.
- Load-use: LoadE = 1, RdE = 3, Rs2D = 3 -> StallF = StallD = FlushE = 1 for exactly one cycle and stall_count = 1. Next cycle, with bubble in E and load in M, Rs2E = 3 -> ForwardBE = 01 one cycle later.
- Branch plus load-use in the same cycle: PCSrcE = 1, LoadE = 1, RdE = 4, Rs1D = 4 -> FlushD = FlushE = StallF = StallD = 1; flush_count and stall_count each increment by 1.
- Reset mid-operation: assert reset asynchronously between edges during a stall -> stall outputs drop immediately, FlushD = FlushE = 1, forwards 00, counters 0. With CNT_W = 2 and 5 consecutive stalls, stall_count holds at 3.
